axil_dot_responder: RTL and testbench

AXI4-Lite responder (subordinate) end of the dot-product accelerator link. It accepts register and vector-element writes from the AXI-Lite master and runs a sequential multiply-accumulate over the stored vectors. It serves status and result reads back to the master. It sits directly on the master's AW/W/B/AR/R channels inside `axi_top`.

---
 rtl/axil_dot_pkg.sv | 44 ++++
 rtl/dot_mac_engine.sv | 84 ++++++++
 rtl/axil_dot_responder.sv | 209 ++++++++++++++++++++
 tb/tb_axil_dot_responder.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axil_dot_pkg.sv
// Shared definitions for the AXI-Lite dot-product responder: register map,
// response codes, engine states and the address decoder.
package axil_dot_pkg;

  localparam logic [7:0] CTRL_OFFS   = 8'h00;
  localparam logic [7:0] STATUS_OFFS = 8'h04;
  localparam logic [7:0] LEN_OFFS    = 8'h08;
  localparam logic [7:0] RESULT_OFFS = 8'h0C;
  localparam logic [7:0] VEC_A_BASE  = 8'h40;
  localparam logic [7:0] VEC_B_BASE  = 8'h80;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DONE
  } eng_state_e;

  typedef enum logic [2:0] {
    REG_CTRL,
    REG_STATUS,
    REG_LEN,
    REG_RESULT,
    REG_VEC_A,
    REG_VEC_B,
    REG_NONE
  } reg_sel_e;

  // word is byte address [7:2]; each vector occupies one 64-byte window
  function automatic reg_sel_e decode_word(input logic [5:0] word);
    reg_sel_e sel;
    sel = REG_NONE;
    if (word == CTRL_OFFS[7:2])                sel = REG_CTRL;
    else if (word == STATUS_OFFS[7:2])         sel = REG_STATUS;
    else if (word == LEN_OFFS[7:2])            sel = REG_LEN;
    else if (word == RESULT_OFFS[7:2])         sel = REG_RESULT;
    else if (word[5:4] == VEC_A_BASE[7:6])     sel = REG_VEC_A;
    else if (word[5:4] == VEC_B_BASE[7:6])     sel = REG_VEC_B;
    return sel;
  endfunction

endpackage

// File: rtl/dot_mac_engine.sv
// Sequential multiply-accumulate engine: one A[i]*B[i] product per cycle,
// result published atomically when the run finishes.
//
// state   | meaning
// --------+---------------------------------------------------------
// ST_IDLE | waiting for start; RESULT and done hold their values
// ST_RUN  | one MAC per cycle, remain counts down to the last element
// ST_DONE | copy acc to RESULT, set done, pulse dot_done
module dot_mac_engine
  import axil_dot_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int MAX_LEN = 16,
  parameter int IDX_W   = $clog2(MAX_LEN),
  parameter int LEN_W   = $clog2(MAX_LEN + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [LEN_W-1:0]  len,
  input  logic [DATA_W-1:0] a_data,
  input  logic [DATA_W-1:0] b_data,
  output logic [IDX_W-1:0]  idx,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] result,
  output logic              dot_done
);

  eng_state_e        state, state_next;
  logic [LEN_W-1:0]  remain;
  logic [DATA_W-1:0] acc;
  logic [DATA_W-1:0] prod;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_next;
  end

  always_comb begin
    state_next = state;
    busy       = (state != ST_IDLE);
    dot_done   = (state == ST_DONE);
    prod       = a_data * b_data;
    case (state)
      ST_IDLE: if (start) state_next = (len == '0) ? ST_DONE : ST_RUN;
      ST_RUN:  if (remain == '0) state_next = ST_DONE;
      ST_DONE: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc    <= '0;
      idx    <= '0;
      remain <= '0;
      result <= '0;
      done   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            acc    <= '0;
            idx    <= '0;
            remain <= len - 1'b1;
            done   <= 1'b0;
          end
        end
        ST_RUN: begin
          acc    <= acc + prod;
          idx    <= idx + 1'b1;
          remain <= remain - 1'b1;
        end
        ST_DONE: begin
          result <= acc;
          done   <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/axil_dot_responder.sv
// AXI4-Lite subordinate for the dot-product accelerator: channel handshakes,
// register decode, the two vector memories and the MAC engine.
module axil_dot_responder
  import axil_dot_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 8,
  parameter int MAX_LEN = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [ADDR_W-1:0]   awaddr,
  input  logic                awvalid,
  output logic                awready,
  input  logic [DATA_W-1:0]   wdata,
  input  logic [DATA_W/8-1:0] wstrb,
  input  logic                wvalid,
  output logic                wready,
  output logic [1:0]          bresp,
  output logic                bvalid,
  input  logic                bready,
  input  logic [ADDR_W-1:0]   araddr,
  input  logic                arvalid,
  output logic                arready,
  output logic [DATA_W-1:0]   rdata,
  output logic [1:0]          rresp,
  output logic                rvalid,
  input  logic                rready,
  output logic                dot_done
);

  localparam int STRB_W = DATA_W / 8;
  localparam int IDX_W  = $clog2(MAX_LEN);
  localparam int LEN_W  = $clog2(MAX_LEN + 1);

  logic              ready_en;
  logic              aw_held, w_held;
  logic [ADDR_W-1:0] aw_addr_q;
  logic [DATA_W-1:0] w_data_q;
  logic [STRB_W-1:0] w_strb_q;
  logic [LEN_W-1:0]  len_q;
  logic              start_q;
  logic [DATA_W-1:0] mem_a [MAX_LEN];
  logic [DATA_W-1:0] mem_b [MAX_LEN];

  logic              eng_busy, eng_done;
  logic [DATA_W-1:0] eng_result;
  logic [IDX_W-1:0]  eng_idx;

  logic              aw_fire, w_fire, commit;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data, len_new, vec_new;
  logic [STRB_W-1:0] wr_strb;
  reg_sel_e          wr_sel, rd_sel;
  logic [IDX_W-1:0]  wr_word, rd_word;
  logic              wr_err, wr_start, wr_len, wr_a, wr_b;
  logic [DATA_W-1:0] rd_data;
  logic [1:0]        rd_resp;
  logic              unused_addr_lsbs;

  function automatic logic [DATA_W-1:0] merge_bytes(input logic [DATA_W-1:0] old_v,
                                                    input logic [DATA_W-1:0] new_v,
                                                    input logic [STRB_W-1:0] strb);
    logic [DATA_W-1:0] r;
    r = old_v;
    for (int b = 0; b < STRB_W; b++)
      if (strb[b]) r[8*b +: 8] = new_v[8*b +: 8];
    return r;
  endfunction

  // ready_en keeps every ready low until the first clock after reset release
  assign awready = ready_en & ~aw_held & ~bvalid;
  assign wready  = ready_en & ~w_held & ~bvalid;
  assign arready = ready_en & ~rvalid;
  assign aw_fire = awvalid & awready;
  assign w_fire  = wvalid & wready;
  assign unused_addr_lsbs = ^{wr_addr[1:0], araddr[1:0]};

  always_comb begin
    commit   = (aw_held | aw_fire) & (w_held | w_fire);
    wr_addr  = aw_held ? aw_addr_q : awaddr;
    wr_data  = w_held ? w_data_q : wdata;
    wr_strb  = w_held ? w_strb_q : wstrb;
    wr_sel   = decode_word(wr_addr[7:2]);
    wr_word  = wr_addr[IDX_W+1:2];
    len_new  = merge_bytes(DATA_W'(len_q), wr_data, wr_strb);
    vec_new  = merge_bytes((wr_sel == REG_VEC_B) ? mem_b[wr_word] : mem_a[wr_word],
                           wr_data, wr_strb);
    wr_err   = 1'b0;
    wr_start = 1'b0;
    wr_len   = 1'b0;
    wr_a     = 1'b0;
    wr_b     = 1'b0;
    case (wr_sel)
      REG_CTRL: begin
        if (wr_strb[0] && wr_data[0]) begin
          if (eng_busy) wr_err = 1'b1;
          else          wr_start = 1'b1;
        end
      end
      REG_LEN: begin
        if (eng_busy || len_new > DATA_W'(MAX_LEN)) wr_err = 1'b1;
        else                                        wr_len = 1'b1;
      end
      REG_VEC_A: if (eng_busy) wr_err = 1'b1; else wr_a = 1'b1;
      REG_VEC_B: if (eng_busy) wr_err = 1'b1; else wr_b = 1'b1;
      default:   wr_err = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ready_en  <= 1'b0;
      aw_held   <= 1'b0;
      w_held    <= 1'b0;
      aw_addr_q <= '0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
      bvalid    <= 1'b0;
      bresp     <= RESP_OKAY;
      len_q     <= '0;
      start_q   <= 1'b0;
    end else begin
      ready_en <= 1'b1;
      start_q  <= 1'b0;
      if (commit) begin
        aw_held <= 1'b0;
        w_held  <= 1'b0;
        bvalid  <= 1'b1;
        bresp   <= wr_err ? RESP_SLVERR : RESP_OKAY;
        start_q <= wr_start;
        if (wr_len) len_q <= len_new[LEN_W-1:0];
      end else begin
        if (aw_fire) begin
          aw_held   <= 1'b1;
          aw_addr_q <= awaddr;
        end
        if (w_fire) begin
          w_held   <= 1'b1;
          w_data_q <= wdata;
          w_strb_q <= wstrb;
        end
        if (bvalid && bready) bvalid <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < MAX_LEN; i++) begin
        mem_a[i] <= '0;
        mem_b[i] <= '0;
      end
    end else if (commit) begin
      if (wr_a) mem_a[wr_word] <= vec_new;
      if (wr_b) mem_b[wr_word] <= vec_new;
    end
  end

  always_comb begin
    rd_sel  = decode_word(araddr[7:2]);
    rd_word = araddr[IDX_W+1:2];
    rd_data = '0;
    rd_resp = RESP_OKAY;
    case (rd_sel)
      REG_STATUS: rd_data = {{(DATA_W-2){1'b0}}, eng_done, eng_busy};
      REG_LEN:    rd_data = DATA_W'(len_q);
      REG_RESULT: rd_data = eng_result;
      REG_VEC_A:  rd_data = mem_a[rd_word];
      REG_VEC_B:  rd_data = mem_b[rd_word];
      REG_NONE:   rd_resp = RESP_SLVERR;
      default:    ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rvalid <= 1'b0;
      rdata  <= '0;
      rresp  <= RESP_OKAY;
    end else if (arvalid && arready) begin
      rvalid <= 1'b1;
      rdata  <= rd_data;
      rresp  <= rd_resp;
    end else if (rvalid && rready) begin
      rvalid <= 1'b0;
    end
  end

  dot_mac_engine #(
    .DATA_W  (DATA_W),
    .MAX_LEN (MAX_LEN),
    .IDX_W   (IDX_W),
    .LEN_W   (LEN_W)
  ) u_engine (
    .clk      (clk),
    .rst      (rst),
    .start    (start_q),
    .len      (len_q),
    .a_data   (mem_a[eng_idx]),
    .b_data   (mem_b[eng_idx]),
    .idx      (eng_idx),
    .busy     (eng_busy),
    .done     (eng_done),
    .result   (eng_result),
    .dot_done (dot_done)
  );

endmodule

// File: tb/tb_axil_dot_responder.sv
// Directed bench for axil_dot_responder: handshakes, register map, error
// responses, engine timing and reset abort.
module tb_axil_dot_responder;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [7:0]  awaddr = '0;
  logic        awvalid = 1'b0, awready;
  logic [31:0] wdata = '0;
  logic [3:0]  wstrb = '0;
  logic        wvalid = 1'b0, wready;
  logic [1:0]  bresp;
  logic        bvalid, bready = 1'b0;
  logic [7:0]  araddr = '0;
  logic        arvalid = 1'b0, arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid, rready = 1'b0;
  logic        dot_done;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int done_cnt = 0;
  int done_cyc = -1;

  axil_dot_responder #(.DATA_W(32), .ADDR_W(8), .MAX_LEN(16)) dut (
    .clk(clk), .rst(rst),
    .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .araddr(araddr), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
    .dot_done(dot_done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (dot_done) begin done_cnt++; done_cyc = cyc; end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic axi_write(input logic [7:0] addr, input logic [31:0] data, input logic [3:0] strb,
                           output logic [1:0] resp, output int t_b);
    int n = 0;
    logic aw_go, w_go;
    @(negedge clk);
    awaddr = addr; awvalid = 1'b1; wdata = data; wstrb = strb; wvalid = 1'b1; bready = 1'b1;
    while ((awvalid || wvalid) && n < 20) begin
      aw_go = awvalid && awready;
      w_go  = wvalid && wready;
      @(negedge clk); n++;
      if (aw_go) awvalid = 1'b0;
      if (w_go)  wvalid = 1'b0;
    end
    while (!bvalid && n < 20) begin @(negedge clk); n++; end
    if (!bvalid) begin
      n_checks++; n_fail++;
      $display("FAIL write_timeout: addr %h got no bvalid, required bvalid=1", addr);
      awvalid = 1'b0; wvalid = 1'b0;
    end
    resp = bresp;
    t_b  = cyc;
  endtask

  task automatic axi_read(input logic [7:0] addr, output logic [31:0] data, output logic [1:0] resp);
    int n = 0;
    logic go;
    @(negedge clk);
    araddr = addr; arvalid = 1'b1; rready = 1'b1;
    while (arvalid && n < 20) begin
      go = arready;
      @(negedge clk); n++;
      if (go) arvalid = 1'b0;
    end
    while (!rvalid && n < 20) begin @(negedge clk); n++; end
    if (!rvalid) begin
      n_checks++; n_fail++;
      $display("FAIL read_timeout: addr %h got no rvalid, required rvalid=1", addr);
      arvalid = 1'b0;
    end
    data = rdata;
    resp = rresp;
  endtask

  task automatic wr(input logic [7:0] addr, input logic [31:0] data);
    logic [1:0] r;
    int t;
    axi_write(addr, data, 4'hF, r, t);
  endtask

  task automatic wait_done(output logic [31:0] st);
    logic [1:0] r;
    int n = 0;
    st = '0;
    while (!st[1] && n < 40) begin axi_read(8'h04, st, r); n++; end
    if (!st[1]) begin
      n_checks++; n_fail++;
      $display("FAIL done_timeout: status %h, required done bit set", st);
    end
  endtask

  task automatic test_reset();
    logic [31:0] d; logic [1:0] r;
    repeat (2) @(negedge clk);
    n_checks++; if ({awready, wready, arready} !== 3'b000) begin n_fail++; $display("FAIL rst_readies: got %b, required 000", {awready, wready, arready}); end
    n_checks++; if ({bvalid, rvalid, dot_done} !== 3'b000) begin n_fail++; $display("FAIL rst_valids: got %b, required 000", {bvalid, rvalid, dot_done}); end
    n_checks++; if ({bresp, rresp, rdata} !== 36'h0) begin n_fail++; $display("FAIL rst_resp_data: got %h, required 0", {bresp, rresp, rdata}); end
    rst = 1'b1;
    @(negedge clk);
    n_checks++; if ({awready, wready, arready} !== 3'b111) begin n_fail++; $display("FAIL post_rst_readies: got %b, required 111", {awready, wready, arready}); end
    axi_read(8'h04, d, r);
    n_checks++; if ({r, d} !== 34'h0) begin n_fail++; $display("FAIL rst_status: got resp %b data %h, required 00/0", r, d); end
    axi_read(8'h0C, d, r);
    n_checks++; if ({r, d} !== 34'h0) begin n_fail++; $display("FAIL rst_result: got resp %b data %h, required 00/0", r, d); end
  endtask

  task automatic test_basic();
    logic [31:0] va[3] = '{32'd7, 32'd3, 32'd6};
    logic [31:0] vb[3] = '{32'd4, 32'd2, 32'd4};
    logic [31:0] d; logic [1:0] r; int t, c0;
    axi_write(8'h08, 32'd3, 4'hF, r, t);
    n_checks++; if (r !== 2'b00) begin n_fail++; $display("FAIL len3_resp: got %b, required 00", r); end
    for (int i = 0; i < 3; i++) begin
      wr(8'(8'h40 + 4*i), va[i]);
      wr(8'(8'h80 + 4*i), vb[i]);
    end
    c0 = done_cnt;
    axi_write(8'h00, 32'd1, 4'hF, r, t);
    n_checks++; if (r !== 2'b00) begin n_fail++; $display("FAIL start_resp: got %b, required 00", r); end
    axi_read(8'h04, d, r);
    n_checks++; if (d !== 32'h1) begin n_fail++; $display("FAIL busy_status: got %h, required 1", d); end
    wait_done(d);
    n_checks++; if (d !== 32'h2) begin n_fail++; $display("FAIL basic_status: got %h, required 2", d); end
    n_checks++; if (done_cyc !== t + 4) begin n_fail++; $display("FAIL basic_dot_done_cycle: got %0d, required %0d", done_cyc, t + 4); end
    n_checks++; if (done_cnt !== c0 + 1) begin n_fail++; $display("FAIL basic_done_count: got %0d, required %0d", done_cnt, c0 + 1); end
    axi_read(8'h0C, d, r);
    n_checks++; if ({r, d} !== {2'b00, 32'd58}) begin n_fail++; $display("FAIL basic_result: got resp %b data %0d, required 00/58", r, d); end
    // R channel held while rready is low
    @(negedge clk); araddr = 8'h0C; arvalid = 1'b1; rready = 1'b0;
    @(negedge clk); arvalid = 1'b0;
    repeat (3) begin
      n_checks++; if ({rvalid, arready, rdata} !== {2'b10, 32'd58}) begin n_fail++; $display("FAIL r_hold: got rvalid %b arready %b rdata %0d, required 1/0/58", rvalid, arready, rdata); end
      @(negedge clk);
    end
    rready = 1'b1;
    @(negedge clk);
    n_checks++; if (rvalid !== 1'b0) begin n_fail++; $display("FAIL r_release: got rvalid %b, required 0", rvalid); end
  endtask

  task automatic test_len_zero();
    logic [31:0] d; logic [1:0] r; int t, c0;
    wr(8'h08, 32'd0);
    c0 = done_cnt;
    axi_write(8'h00, 32'd1, 4'hF, r, t);
    repeat (3) @(negedge clk);
    n_checks++; if (done_cyc !== t + 1) begin n_fail++; $display("FAIL len0_dot_done_cycle: got %0d, required %0d", done_cyc, t + 1); end
    n_checks++; if (done_cnt !== c0 + 1) begin n_fail++; $display("FAIL len0_done_count: got %0d, required %0d", done_cnt, c0 + 1); end
    axi_read(8'h04, d, r);
    n_checks++; if (d !== 32'h2) begin n_fail++; $display("FAIL len0_status: got %h, required 2", d); end
    axi_read(8'h0C, d, r);
    n_checks++; if (d !== 32'h0) begin n_fail++; $display("FAIL len0_result: got %h, required 0", d); end
  endtask

  task automatic test_errors();
    logic [31:0] d; logic [1:0] r; int t, c0;
    axi_write(8'h0C, 32'hDEAD, 4'hF, r, t);
    n_checks++; if (r !== 2'b10) begin n_fail++; $display("FAIL wr_result_resp: got %b, required 10", r); end
    axi_read(8'h0C, d, r);
    n_checks++; if (d !== 32'h0) begin n_fail++; $display("FAIL wr_result_effect: got %h, required 0", d); end
    axi_write(8'h08, 32'd17, 4'hF, r, t);
    n_checks++; if (r !== 2'b10) begin n_fail++; $display("FAIL len17_resp: got %b, required 10", r); end
    axi_read(8'h08, d, r);
    n_checks++; if (d !== 32'h0) begin n_fail++; $display("FAIL len17_effect: got %h, required 0", d); end
    axi_write(8'h08, 32'd16, 4'hF, r, t);
    axi_read(8'h08, d, r);
    n_checks++; if (d !== 32'd16) begin n_fail++; $display("FAIL len16: got %0d, required 16", d); end
    axi_write(8'h04, 32'h3, 4'hF, r, t);
    n_checks++; if (r !== 2'b10) begin n_fail++; $display("FAIL wr_status_resp: got %b, required 10", r); end
    axi_write(8'h10, 32'h1, 4'hF, r, t);
    n_checks++; if (r !== 2'b10) begin n_fail++; $display("FAIL wr_unmapped_resp: got %b, required 10", r); end
    axi_read(8'hFC, d, r);
    n_checks++; if ({r, d} !== {2'b10, 32'h0}) begin n_fail++; $display("FAIL rd_unmapped: got resp %b data %h, required 10/0", r, d); end
    axi_read(8'h00, d, r);
    n_checks++; if ({r, d} !== 34'h0) begin n_fail++; $display("FAIL rd_ctrl: got resp %b data %h, required 00/0", r, d); end
    axi_write(8'h44, 32'hAABBCCDD, 4'b0101, r, t);
    axi_read(8'h44, d, r);
    n_checks++; if (d !== 32'h00BB00DD) begin n_fail++; $display("FAIL strobe_merge: got %h, required 00bb00dd", d); end
    wr(8'h44, 32'd3);
    // LEN=16 run over A={7,3,6,0..}, B={4,2,4,0..}; writes during it must bounce
    c0 = done_cnt;
    axi_write(8'h00, 32'd1, 4'hF, r, t);
    axi_write(8'h40, 32'h55, 4'hF, r, c0);
    n_checks++; if (r !== 2'b10) begin n_fail++; $display("FAIL busy_vec_resp: got %b, required 10", r); end
    axi_write(8'h08, 32'd1, 4'hF, r, c0);
    n_checks++; if (r !== 2'b10) begin n_fail++; $display("FAIL busy_len_resp: got %b, required 10", r); end
    c0 = done_cnt;
    axi_write(8'h00, 32'd1, 4'hF, r, c0);
    n_checks++; if (r !== 2'b10) begin n_fail++; $display("FAIL busy_start_resp: got %b, required 10", r); end
    c0 = done_cnt;
    wait_done(d);
    repeat (20) @(negedge clk);
    n_checks++; if (done_cyc !== t + 17) begin n_fail++; $display("FAIL len16_dot_done_cycle: got %0d, required %0d", done_cyc, t + 17); end
    n_checks++; if (done_cnt !== c0 + 1) begin n_fail++; $display("FAIL len16_done_count: got %0d, required %0d", done_cnt, c0 + 1); end
    axi_read(8'h40, d, r);
    n_checks++; if (d !== 32'd7) begin n_fail++; $display("FAIL busy_vec_effect: got %h, required 7", d); end
    axi_read(8'h08, d, r);
    n_checks++; if (d !== 32'd16) begin n_fail++; $display("FAIL busy_len_effect: got %0d, required 16", d); end
    axi_read(8'h0C, d, r);
    n_checks++; if (d !== 32'd58) begin n_fail++; $display("FAIL len16_result: got %0d, required 58", d); end
  endtask

  task automatic test_w_before_aw();
    logic [31:0] d; logic [1:0] r;
    @(negedge clk);
    wdata = 32'h12345678; wstrb = 4'hF; wvalid = 1'b1; bready = 1'b0;
    n_checks++; if (wready !== 1'b1) begin n_fail++; $display("FAIL early_w_ready: got %b, required 1", wready); end
    @(negedge clk); wvalid = 1'b0;
    n_checks++; if ({wready, awready, bvalid} !== 3'b010) begin n_fail++; $display("FAIL w_held: got %b, required 010", {wready, awready, bvalid}); end
    repeat (2) @(negedge clk);
    awaddr = 8'hBC; awvalid = 1'b1;
    @(negedge clk); awvalid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      n_checks++; if ({bvalid, awready, wready, bresp} !== 5'b10000) begin n_fail++; $display("FAIL b_hold%0d: got %b, required 10000", i, {bvalid, awready, wready, bresp}); end
      @(negedge clk);
    end
    bready = 1'b1;
    @(negedge clk);
    n_checks++; if ({bvalid, awready, wready} !== 3'b011) begin n_fail++; $display("FAIL b_release: got %b, required 011", {bvalid, awready, wready}); end
    @(negedge clk);
    n_checks++; if (bvalid !== 1'b0) begin n_fail++; $display("FAIL single_b: got bvalid %b, required 0", bvalid); end
    axi_read(8'hBC, d, r);
    n_checks++; if (d !== 32'h12345678) begin n_fail++; $display("FAIL w_before_aw_data: got %h, required 12345678", d); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] d; logic [1:0] r;
    @(negedge clk);
    awaddr = 8'h08; wdata = 32'd5; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
    araddr = 8'h08; arvalid = 1'b1; rready = 1'b1;
    n_checks++; if ({awready, wready, arready} !== 3'b111) begin n_fail++; $display("FAIL b2b_ready0: got %b, required 111", {awready, wready, arready}); end
    @(negedge clk);
    arvalid = 1'b0;
    n_checks++; if ({bvalid, awready, rvalid, rdata} !== {3'b101, 32'd16}) begin n_fail++; $display("FAIL b2b_cycle1: got bvalid %b awready %b rvalid %b rdata %0d, required 1/0/1/16", bvalid, awready, rvalid, rdata); end
    awaddr = 8'h48; wdata = 32'h22;
    @(negedge clk);
    n_checks++; if ({bvalid, awready, wready} !== 3'b011) begin n_fail++; $display("FAIL b2b_cycle2: got %b, required 011", {bvalid, awready, wready}); end
    @(negedge clk);
    awvalid = 1'b0; wvalid = 1'b0;
    n_checks++; if (bvalid !== 1'b1) begin n_fail++; $display("FAIL b2b_cycle3: got bvalid %b, required 1", bvalid); end
    axi_read(8'h08, d, r);
    n_checks++; if (d !== 32'd5) begin n_fail++; $display("FAIL b2b_len: got %0d, required 5", d); end
    axi_read(8'h48, d, r);
    n_checks++; if (d !== 32'h22) begin n_fail++; $display("FAIL b2b_vec: got %h, required 22", d); end
  endtask

  task automatic test_wrap();
    logic [31:0] d; logic [1:0] r; int t;
    wr(8'h08, 32'd2);
    wr(8'h40, 32'hFFFF_FFFF); wr(8'h44, 32'hFFFF_FFFF);
    wr(8'h80, 32'hFFFF_FFFF); wr(8'h84, 32'hFFFF_FFFF);
    axi_write(8'h00, 32'd1, 4'hF, r, t);
    wait_done(d);
    axi_read(8'h0C, d, r);
    n_checks++; if (d !== 32'h0000_0002) begin n_fail++; $display("FAIL wrap_result: got %h, required 00000002", d); end
  endtask

  task automatic test_reset_mid_run();
    logic [31:0] d; logic [1:0] r; int t, c0;
    wr(8'h08, 32'd16);
    axi_write(8'h00, 32'd1, 4'hF, r, t);
    repeat (5) @(negedge clk);
    c0 = done_cnt;
    rst = 1'b0;
    #1;
    n_checks++; if ({awready, wready, arready, bvalid, rvalid, dot_done} !== 6'b0) begin n_fail++; $display("FAIL midrun_rst_ctrl: got %b, required 000000", {awready, wready, arready, bvalid, rvalid, dot_done}); end
    n_checks++; if ({bresp, rresp, rdata} !== 36'h0) begin n_fail++; $display("FAIL midrun_rst_data: got %h, required 0", {bresp, rresp, rdata}); end
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (20) @(negedge clk);
    n_checks++; if (done_cnt !== c0) begin n_fail++; $display("FAIL midrun_no_done: got %0d pulses, required %0d", done_cnt, c0); end
    axi_read(8'h04, d, r);
    n_checks++; if (d !== 32'h0) begin n_fail++; $display("FAIL midrun_status: got %h, required 0", d); end
    axi_read(8'h08, d, r);
    n_checks++; if (d !== 32'h0) begin n_fail++; $display("FAIL midrun_len: got %h, required 0", d); end
    axi_read(8'h40, d, r);
    n_checks++; if (d !== 32'h0) begin n_fail++; $display("FAIL midrun_mem: got %h, required 0", d); end
    wr(8'h08, 32'd2);
    wr(8'h40, 32'd5); wr(8'h44, 32'd6);
    wr(8'h80, 32'd7); wr(8'h84, 32'd8);
    axi_write(8'h00, 32'd1, 4'hF, r, t);
    wait_done(d);
    n_checks++; if (done_cyc !== t + 3) begin n_fail++; $display("FAIL post_rst_dot_done_cycle: got %0d, required %0d", done_cyc, t + 3); end
    axi_read(8'h0C, d, r);
    n_checks++; if (d !== 32'd83) begin n_fail++; $display("FAIL post_rst_result: got %0d, required 83", d); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_len_zero();
    test_errors();
    test_w_before_aw();
    test_back_to_back();
    test_wrap();
    test_reset_mid_run();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
